spi_slave_frame: RTL
====================

SPI_SLAVE_FRAME -- requirements
Module: spi_slave_frame

Interface
REQ-001 SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-002 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have parameter BYTES_PER_FRAME, default 2, bytes per n_cs assertion (range 1..255).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, entries per internal FIFO (power of 2, range 4..128).
REQ-005 SHALL have port: sys_clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: n_cs  input  1  chip select from external master, asynchronous, active-low.
REQ-008 SHALL have port: sclk  input  1  SPI clock from external master, asynchronous.
REQ-009 SHALL have port: mosi  input  1  serial data from master, MSB first.
REQ-010 SHALL have port: miso  output  1  serial data to master, MSB first.
REQ-011 SHALL have port: miso_oe  output  1  miso drive enable, high while synchronized n_cs is low.
REQ-012 SHALL have ports: tx_din  input  8; tx_wrreq  input  1; tx_full  output  1 -- TX FIFO write side.
REQ-013 SHALL have ports: rx_rdreq  input  1; rx_dout  output  8; rx_empty  output  1; rx_len  output  8 -- RX FIFO read side, rx_len = occupancy zero-extended.
REQ-014 SHALL have outputs frame_done, frame_err, tx_underrun, rx_overflow, each 1 bit, each a one-cycle pulse.

Function
REQ-015 SHALL pass n_cs, sclk, mosi through 2-flop synchronizers; edges detected on synchronized values; n_cs synchronizer flop resets to 1, sclk flop to CPOL.
REQ-016 SHALL support sclk up to sys_clk/4 at 50% duty; behaviour beyond that is undefined.
REQ-017 SHALL have FSM states IDLE, ACTIVE, FLUSH.
REQ-018 IDLE -> ACTIVE on synchronized n_cs falling; byte counter and bit counter cleared; shift register loaded with TX FIFO head (one pop), or 0x00 plus tx_underrun pulse if TX FIFO empty.
REQ-019 Leading edge = sclk transition away from CPOL; trailing edge = transition back to CPOL.
REQ-020 CPHA=0: miso = shift-register MSB from load; sample mosi on leading edge; shift on trailing edge.
REQ-021 CPHA=1: shift out on leading edge (first leading edge presents MSB); sample mosi on trailing edge.
REQ-022 SHALL increment 3-bit bit counter per sample; on 8th sample, assembled byte pushed to RX FIFO in same cycle.
REQ-023 RX FIFO full at push: byte dropped, rx_overflow pulsed, FIFO contents unchanged.
REQ-024 After 8th sample, if byte counter < BYTES_PER_FRAME-1: next TX byte popped and loaded for next shift edge (0x00 plus tx_underrun if empty); byte counter incremented.
REQ-025 After 8th sample of byte BYTES_PER_FRAME-1: frame_done pulse, state -> FLUSH, no further TX pops; miso held 0.
REQ-026 FLUSH: further sclk edges ignored; -> IDLE on synchronized n_cs rising.
REQ-027 Synchronized n_cs rising in ACTIVE: partial byte discarded, frame_err pulse, state -> IDLE; bytes already pushed kept.
REQ-028 SHALL drive miso to 0 and miso_oe to 0 in IDLE.
REQ-029 TX FIFO write with tx_full=1 SHALL be ignored; RX read with rx_empty=1 SHALL be ignored, rx_dout unchanged.
REQ-030 rx_dout SHALL be show-ahead (head valid while rx_empty=0); rx_rdreq pops in same cycle.
REQ-031 Simultaneous push and pop on either FIFO SHALL both occur; occupancy unchanged; push into full FIFO allowed when pop in same cycle.

Reset
REQ-032 On n_rst low: state IDLE, counters 0, both FIFOs empty, tx_full=0, rx_empty=1, rx_len=0, rx_dout=0, miso=0, miso_oe=0, all pulses 0.
REQ-033 Reset mid-frame SHALL abort without frame_err; after release, frame starts only on a new n_cs falling edge.

Verification
REQ-034 Mode 0, BPF=2, TX preload 0xA5,0x3C, master sends 0x12,0x34 -> miso bits A5,3C; rx_dout 0x12 then 0x34; rx_len=2; one frame_done.
REQ-035 Each of modes 1,2,3 with same stimulus -> identical bytes both directions.
REQ-036 TX FIFO empty at frame start -> miso all zero, two tx_underrun pulses, RX still receives both bytes.
REQ-037 n_cs released after 11 bits -> frame_err once, rx_len=1 (first byte only), no frame_done.
REQ-038 RX FIFO pre-filled to FIFO_DEPTH, full frame sent -> two rx_overflow pulses, rx_len=FIFO_DEPTH, contents unchanged.
REQ-039 n_rst asserted after 5 bits, released, new full frame -> only new frame bytes in RX, no frame_err.

Source files
------------

// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave exchanging fixed-length frames of bytes between an
// external master and two show-ahead FIFOs (TX feeds miso, RX collects mosi).
// All SPI pins are oversampled in the sys_clk domain.
module spi_slave_frame #(
    parameter int unsigned CPOL            = 0,
    parameter int unsigned CPHA            = 0,
    parameter int unsigned BYTES_PER_FRAME = 2,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic       sys_clk,
    input  logic       n_rst,
    input  logic       n_cs,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_din,
    input  logic       tx_wrreq,
    output logic       tx_full,
    input  logic       rx_rdreq,
    output logic [7:0] rx_dout,
    output logic       rx_empty,
    output logic [7:0] rx_len,
    output logic       frame_done,
    output logic       frame_err,
    output logic       tx_underrun,
    output logic       rx_overflow
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [7:0] LAST_BYTE  = 8'(BYTES_PER_FRAME - 1);
    localparam logic IDLE_POL         = 1'(CPOL);
    localparam logic SHIFT_LEAD       = (CPHA != 0);

    typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

    // Synchronizers and edge detection
    logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic       cs_prev_q, sclk_prev_q;
    logic [1:0] settle_q;
    logic       armed_q;
    logic       cs_s, sclk_s, mosi_s;
    logic       cs_fall, cs_rise, sclk_chg, lead_edge, trail_edge, sample_edge, shift_edge;

    // Frame engine state
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [6:0] rx_sh_q, rx_sh_d;
    logic       out_q, out_d;
    logic       skip_q, skip_d;
    logic       load_req;
    logic       done_d, err_d, underrun_d, overflow_d;

    // FIFOs
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [PW-1:0] tx_cnt, rx_cnt;
    logic          tx_empty, tx_pop_req, tx_pop, tx_push;
    logic [7:0]    tx_head;
    logic          rx_full, rx_push_req, rx_push, rx_pop;
    logic [7:0]    rx_push_data;

    assign cs_s   = cs_sync_q[1];
    assign sclk_s = sclk_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    // A falling n_cs only counts once n_cs has been seen high after reset, so a
    // chip select held low through reset cannot start a frame.
    assign cs_fall     = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;
    assign sclk_chg    = sclk_s ^ sclk_prev_q;
    assign lead_edge   = sclk_chg & (sclk_s != IDLE_POL);
    assign trail_edge  = sclk_chg & (sclk_s == IDLE_POL);
    assign sample_edge = SHIFT_LEAD ? trail_edge : lead_edge;
    assign shift_edge  = SHIFT_LEAD ? lead_edge : trail_edge;

    // Two-flop synchronizers, edge history and post-reset arming of n_cs
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            cs_sync_q   <= 2'b11;
            sclk_sync_q <= {2{IDLE_POL}};
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= IDLE_POL;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], n_cs};
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd3 && cs_s) armed_q <= 1'b1;
        end
    end

    // Frame engine next-state: bit/byte sequencing, TX loads and RX pushes
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        tx_sh_d      = tx_sh_q;
        rx_sh_d      = rx_sh_q;
        out_d        = out_q;
        skip_d       = skip_q;
        load_req     = 1'b0;
        rx_push_req  = 1'b0;
        rx_push_data = {rx_sh_q, mosi_s};
        done_d       = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StActive;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 8'd0;
                    rx_sh_d    = 7'd0;
                    out_d      = 1'b0;
                    skip_d     = 1'b0;
                    load_req   = 1'b1;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (sample_edge) begin
                    rx_sh_d   = rx_push_data[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_push_req = 1'b1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            done_d  = 1'b1;
                            state_d = StFlush;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            load_req   = 1'b1;
                            // In mode CPHA=0 the new MSB is already on miso, so
                            // the trailing edge that closes this byte must not shift.
                            skip_d     = ~SHIFT_LEAD;
                        end
                    end
                end else if (shift_edge) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        out_d   = tx_sh_q[7];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            StFlush: begin
                if (cs_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        tx_pop_req = load_req;
        underrun_d = load_req & tx_empty;
        if (load_req) tx_sh_d = tx_empty ? 8'h00 : tx_head;
    end

    // Frame engine registers and output pulses
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 8'd0;
            tx_sh_q     <= 8'd0;
            rx_sh_q     <= 7'd0;
            out_q       <= 1'b0;
            skip_q      <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            out_q       <= out_d;
            skip_q      <= skip_d;
            frame_done  <= done_d;
            frame_err   <= err_d;
            tx_underrun <= underrun_d;
            rx_overflow <= overflow_d;
        end
    end

    assign miso    = (state_q == StActive) ? (SHIFT_LEAD ? out_q : tx_sh_q[7]) : 1'b0;
    assign miso_oe = (state_q != StIdle) & ~cs_s;

    // TX FIFO: a push into a full FIFO is accepted only alongside a pop
    assign tx_cnt   = tx_wr_q - tx_rd_q;
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == DEPTH_P);
    assign tx_pop   = tx_pop_req & ~tx_empty;
    assign tx_push  = tx_wrreq & (~tx_full | tx_pop);
    assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];

    // TX FIFO pointers
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
        end
    end

    // TX FIFO storage
    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= tx_din;
    end

    // RX FIFO: show-ahead head, full-at-push drops the byte
    assign rx_cnt     = rx_wr_q - rx_rd_q;
    assign rx_empty   = (rx_cnt == '0);
    assign rx_full    = (rx_cnt == DEPTH_P);
    assign rx_pop     = rx_rdreq & ~rx_empty;
    assign rx_push    = rx_push_req & (~rx_full | rx_pop);
    assign overflow_d = rx_push_req & rx_full & ~rx_pop;
    assign rx_dout    = rx_mem[rx_rd_q[AW-1:0]];
    assign rx_len     = 8'(rx_cnt);

    // RX FIFO pointers and storage; storage is cleared so rx_dout reads 0 after reset
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            rx_mem  <= '{default: 8'h00};
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_q[AW-1:0]] <= rx_push_data;
                rx_wr_q                 <= rx_wr_q + 1'b1;
            end
            if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
        end
    end

endmodule
